// File: rtl/ps2_key_pkg.sv
// Shared definitions for the PS/2 keypad decoder: key codes, prefix bytes, scancode map.
// Latency: not applicable (types, constants and a pure function only).
// Backpressure: not applicable.
package ps2_key_pkg;

    // Decoded key value. KEY_NONE marks a scancode with no key assigned.
    typedef enum logic [3:0] {
        KEY_CLEAR = 4'd0,
        KEY_1     = 4'd1,
        KEY_2     = 4'd2,
        KEY_3     = 4'd3,
        KEY_4     = 4'd4,
        KEY_5     = 4'd5,
        KEY_6     = 4'd6,
        KEY_7     = 4'd7,
        KEY_8     = 4'd8,
        KEY_9     = 4'd9,
        KEY_ENTER = 4'd10,
        KEY_UP    = 4'd11,
        KEY_DOWN  = 4'd12,
        KEY_LEFT  = 4'd13,
        KEY_RIGHT = 4'd14,
        KEY_NONE  = 4'd15
    } key_t;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Map {extended flag, scancode byte} from scancode set 2 onto a key.
    function automatic key_t sc_to_key(input logic [8:0] code);
        key_t k;
        case (code)
            9'h016:                 k = KEY_1;
            9'h01E:                 k = KEY_2;
            9'h026:                 k = KEY_3;
            9'h025:                 k = KEY_4;
            9'h02E:                 k = KEY_5;
            9'h036:                 k = KEY_6;
            9'h03D:                 k = KEY_7;
            9'h03E:                 k = KEY_8;
            9'h046:                 k = KEY_9;
            9'h045, 9'h066, 9'h171: k = KEY_CLEAR;
            9'h05A:                 k = KEY_ENTER;
            9'h175:                 k = KEY_UP;
            9'h172:                 k = KEY_DOWN;
            9'h16B:                 k = KEY_LEFT;
            9'h174:                 k = KEY_RIGHT;
            default:                k = KEY_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Watchdog for the gap between a prefix byte and the byte that completes it.
// Latency: expired is combinational from the count; it is high on the edge the count reaches TIMEOUT_CYCLES-1.
// Backpressure: none; the counter saturates instead of wrapping and clears on clr or when not running.
module ps2_prefix_timer #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int             CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  PRE  = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] r_cnt;

    // Count idle cycles while a prefix is pending; hold at LAST rather than wrap.
    always_ff @(posedge clk) begin
        if (!reset || clr || !run) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // The edge on which the count steps onto LAST is the timeout edge.
    assign expired = run && (r_cnt >= PRE);

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 set-2 scancodes (E0/F0 prefixes) into keypad key presses; KEY_REPEAT_EN passes typematic repeats.
// Latency: key_valid/key_code/key_err are registered, one clock after the rx_ready strobe (or timeout edge).
// Backpressure: none; every rx_ready strobe is consumed, including back-to-back strobes.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t       r_state;
    logic [8:0]   r_held;
    logic         r_key_valid;
    logic         r_key_err;
    key_t         r_key_code;

    logic         w_run;
    logic         w_expired;
    state_t       w_eff_state;
    logic         w_is_ext;
    logic         w_is_brk;
    logic         w_is_prefix;
    logic         w_ext;
    logic [8:0]   w_code;
    key_t         w_key;
    logic         w_mapped;
    logic         w_new;
    logic         w_make;
    logic         w_break;

    assign w_run = (r_state != ST_IDLE);

    ps2_prefix_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (w_run),
        .clr     (rx_ready),
        .expired (w_expired)
    );

    // A byte landing on the timeout edge is decoded as if the prefix had already expired.
    assign w_eff_state = w_expired ? ST_IDLE : r_state;

    assign w_is_ext    = (rx_data == SC_EXT);
    assign w_is_brk    = (rx_data == SC_BRK);
    assign w_is_prefix = w_is_ext || w_is_brk;
    assign w_ext       = (w_eff_state == ST_EXT) || (w_eff_state == ST_EXT_BRK);
    assign w_code      = {w_ext, rx_data};
    assign w_key       = sc_to_key(w_code);
    assign w_mapped    = (w_key != KEY_NONE);

`ifdef KEY_REPEAT_EN
    assign w_new = 1'b1;
`else
    // Typematic repeats of the key already held down are swallowed.
    assign w_new = (r_held != w_code);
`endif

    assign w_make  = rx_ready && !w_is_prefix && w_mapped &&
                     ((w_eff_state == ST_IDLE) || (w_eff_state == ST_EXT));
    assign w_break = rx_ready && !w_is_prefix &&
                     ((w_eff_state == ST_BRK) || (w_eff_state == ST_EXT_BRK));

    // Prefix-tracking FSM; also raises key_err on a bad prefix pair or a prefix timeout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_key_err <= 1'b0;
        end else begin
            r_key_err <= 1'b0;
            if (rx_ready) begin
                case (w_eff_state)
                    ST_IDLE: begin
                        if (w_is_ext)      r_state <= ST_EXT;
                        else if (w_is_brk) r_state <= ST_BRK;
                        else               r_state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (w_is_brk)      r_state <= ST_EXT_BRK;
                        else if (w_is_ext) r_state <= ST_EXT;
                        else               r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_key_err <= w_is_prefix;
                    end
                endcase
            end else if (w_expired) begin
                r_state   <= ST_IDLE;
                r_key_err <= 1'b1;
            end
        end
    end

    // Track the held key and publish new presses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_held      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= KEY_NONE;
        end else begin
            r_key_valid <= 1'b0;
            if (w_make) begin
                r_held <= w_code;
                if (w_new) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_key;
                end
            end else if (w_break && (r_held == w_code)) begin
                r_held <= '0;
            end
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_err   = r_key_err;

endmodule
